// File: rtl/alu_issue_queue.sv
// Instruction FIFO in front of the combinational control_unit ALU. The head entry is
// driven to the ALU, and its answer is captured into a valid/ready result register.
module alu_issue_queue #(
   parameter int  DEPTH = 4,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [18:0]   in_incode,
   output logic [18:0]   alu_incode,
   input  logic [7:0]    alu_ans,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [2:0]    res_opcode,
   output logic [7:0]    res_ans,
   output logic [CW-1:0] count,
   output logic [7:0]    nop_drops
);

   localparam int PW = $clog2(DEPTH);

   logic [18:0]   mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          res_valid_q, res_valid_d;
   logic [2:0]    res_opcode_q, res_opcode_d;
   logic [7:0]    res_ans_q, res_ans_d;
   logic [7:0]    nop_drops_q, nop_drops_d;

   logic [18:0] head;
   logic        not_empty, head_nop, push, issue, drop, pop;

   assign head      = mem_q[rd_ptr_q];
   assign not_empty = (count_q != '0);
   assign head_nop  = (head[18:16] == 3'b000);
   assign in_ready  = (count_q != CW'(DEPTH));
   assign push      = in_valid && in_ready && !flush;
   assign issue     = not_empty && !head_nop && (!res_valid_q || res_ready);
   // Opcode-000 heads are discarded even while the result register is stalled.
   assign drop      = not_empty && head_nop;
   assign pop       = issue || drop;

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      res_valid_d  = res_valid_q;
      res_opcode_d = res_opcode_q;
      res_ans_d    = res_ans_q;
      nop_drops_d  = nop_drops_q;
      if (flush) begin
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         count_d      = '0;
         res_valid_d  = 1'b0;
         res_opcode_d = '0;
         res_ans_d    = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
         if (drop) nop_drops_d = nop_drops_q + 8'd1;
         if (issue) begin
            res_valid_d  = 1'b1;
            res_opcode_d = head[18:16];
            res_ans_d    = alu_ans;
         end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         res_valid_q  <= 1'b0;
         res_opcode_q <= '0;
         res_ans_q    <= '0;
         nop_drops_q  <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         res_valid_q  <= res_valid_d;
         res_opcode_q <= res_opcode_d;
         res_ans_q    <= res_ans_d;
         nop_drops_q  <= nop_drops_d;
      end
   end

   // Storage needs no reset; validity is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (rst_n && push) mem_q[wr_ptr_q] <= in_incode;
   end

   assign alu_incode = not_empty ? head : 19'b0;
   assign res_valid  = res_valid_q;
   assign res_opcode = res_opcode_q;
   assign res_ans    = res_ans_q;
   assign count      = count_q;
   assign nop_drops  = nop_drops_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: XOR ALU stub, queue-based reference model checked every cycle.
module tb_alu_issue_queue;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n, flush, in_valid, res_ready;
   logic [18:0]   in_incode, alu_incode;
   logic [7:0]    alu_ans, res_ans, nop_drops;
   logic          in_ready, res_valid;
   logic [2:0]    res_opcode;
   logic [CW-1:0] count;

   int tests = 0;
   int fails = 0;

   // Reference model state
   logic [18:0] mq[$];
   logic        m_rv;
   logic [2:0]  m_op;
   logic [7:0]  m_ans;
   logic [7:0]  m_nops;

   always #5 clk = ~clk;

   assign alu_ans = alu_incode[15:8] ^ alu_incode[7:0];

   alu_issue_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_incode(in_incode), .alu_incode(alu_incode), .alu_ans(alu_ans),
      .res_valid(res_valid), .res_ready(res_ready), .res_opcode(res_opcode),
      .res_ans(res_ans), .count(count), .nop_drops(nop_drops)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance the model by one edge from the current inputs, clock the DUT, compare all outputs.
   task automatic step();
      logic rdy, pushed;
      logic [18:0] h;
      rdy    = (mq.size() != DEPTH);
      pushed = 1'b0;
      if (!rst_n) begin
         mq.delete(); m_rv = 0; m_op = 0; m_ans = 0; m_nops = 0;
      end else if (flush) begin
         mq.delete(); m_rv = 0; m_op = 0; m_ans = 0;
      end else begin
         pushed = in_valid && rdy;
         if (mq.size() > 0 && mq[0][18:16] == 3'b000) begin
            void'(mq.pop_front());
            m_nops = m_nops + 8'd1;
            if (m_rv && res_ready) m_rv = 0;
         end else if (mq.size() > 0 && (!m_rv || res_ready)) begin
            h = mq.pop_front();
            m_rv = 1; m_op = h[18:16]; m_ans = h[15:8] ^ h[7:0];
         end else if (m_rv && res_ready) begin
            m_rv = 0;
         end
         if (pushed) mq.push_back(in_incode);
      end
      @(posedge clk);
      #1;
      chk("count", 32'(count), 32'(mq.size()));
      chk("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
      chk("alu_incode", 32'(alu_incode), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
      chk("res_valid", 32'(res_valid), 32'(m_rv));
      chk("res_opcode", 32'(res_opcode), 32'(m_op));
      chk("res_ans", 32'(res_ans), 32'(m_ans));
      chk("nop_drops", 32'(nop_drops), 32'(m_nops));
   endtask

   initial begin
      logic [7:0] saved_ans;
      m_rv = 0; m_op = 0; m_ans = 0; m_nops = 0;
      rst_n = 0; flush = 0; in_valid = 0; in_incode = '0; res_ready = 0;
      step(); step();
      chk("reset_count", 32'(count), 32'd0);
      chk("reset_res_valid", 32'(res_valid), 32'd0);
      rst_n = 1;

      // Single op
      res_ready = 1; in_valid = 1; in_incode = 19'b0010010001100010110;
      step();
      in_valid = 0;
      step();
      chk("single_valid", 32'(res_valid), 32'd1);
      chk("single_op", 32'(res_opcode), 32'd1);
      chk("single_ans", 32'(res_ans), 32'h35);
      step();
      chk("single_done_valid", 32'(res_valid), 32'd0);
      chk("single_done_count", 32'(count), 32'd0);

      // Back-to-back stream
      for (int op = 1; op <= 7; op++) begin
         in_valid = 1; in_incode = {3'(op), 8'h23, 8'h16};
         step();
         chk("b2b_count_le1", 32'(count <= 1), 32'd1);
         if (op > 1) begin
            chk("b2b_valid", 32'(res_valid), 32'd1);
            chk("b2b_op", 32'(res_opcode), 32'(op - 1));
            chk("b2b_ans", 32'(res_ans), 32'h35);
         end
      end
      in_valid = 0;
      step();
      chk("b2b_last_op", 32'(res_opcode), 32'd7);
      step();

      // Backpressure and full
      res_ready = 0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1; in_incode = {3'(i % 7 + 1), 8'(i * 17), 8'h5a};
         step();
      end
      chk("full_count", 32'(count), 32'd4);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_first_op", 32'(res_opcode), 32'd1);
      res_ready = 1;
      step();
      chk("first_pop_in_ready", 32'(in_ready), 32'd1);
      in_valid = 0;
      for (int i = 0; i < 7; i++) step();
      chk("drain_empty", 32'(count), 32'd0);

      // NOP drop with a pending result
      res_ready = 0; in_valid = 1; in_incode = {3'b011, 8'hc3, 8'h0f};
      step();
      in_valid = 0;
      step();
      saved_ans = res_ans;
      in_valid = 1; in_incode = {3'b000, 8'h11, 8'h22}; step();
      in_incode = {3'b010, 8'h44, 8'h18}; step();
      in_incode = {3'b000, 8'h33, 8'h77}; step();
      in_valid = 0;
      step(); step();
      chk("nop_ans_kept", 32'(res_ans), 32'(saved_ans));
      chk("nop_op2_waits", 32'(alu_incode[18:16]), 32'd2);
      res_ready = 1;
      step(); step(); step();
      chk("nop_drops2", 32'(nop_drops), 32'd2);

      // Flush mid-operation
      res_ready = 0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1; in_incode = {3'b101, 8'(i), 8'hf0};
         step();
      end
      chk("pre_flush_count", 32'(count), 32'd3);
      flush = 1; in_valid = 1;
      step();
      flush = 0; in_valid = 0;
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_res_valid", 32'(res_valid), 32'd0);
      chk("flush_nops_kept", 32'(nop_drops), 32'd2);

      // Reset mid-operation
      for (int i = 0; i < 4; i++) begin
         in_valid = 1; in_incode = {3'b110, 8'(i + 9), 8'h0c};
         step();
      end
      rst_n = 0; in_valid = 1;
      step();
      rst_n = 1; in_valid = 0;
      chk("rst_nops", 32'(nop_drops), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_ans", 32'(res_ans), 32'd0);

      // Randomized wrap-around traffic
      for (int i = 0; i < 300; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_incode = {($urandom_range(0, 5) == 0) ? 3'b000 : 3'($urandom_range(1, 7)),
                      8'($urandom), 8'($urandom)};
         res_ready = $urandom_range(0, 1) == 1;
         flush     = ($urandom_range(0, 60) == 0);
         step();
      end
      flush = 0; in_valid = 0; res_ready = 1;
      for (int i = 0; i < 8; i++) step();
      chk("final_empty", 32'(count), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
